// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrates the register file's single write port between
// the single-cycle ALU path (priority, no backpressure) and the buffered
// long-latency memory/divide path. A head entry that keeps losing to the ALU
// eventually raises alu_stall so the buffered result can drain.
// Optional macro WB_PERF_COUNTERS_EN adds stall_cycles / mem_block_cycles.
module regfile_writeback #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGISTERS = 32,
   parameter int FIFO_DEPTH    = 2,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             alu_valid,
   input  logic [$clog2(NUM_REGISTERS)-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0]            alu_data,
   output logic                             alu_stall,
   input  logic                             mem_valid,
   output logic                             mem_ready,
   input  logic [$clog2(NUM_REGISTERS)-1:0] mem_rd,
   input  logic [DATA_WIDTH-1:0]            mem_data,
   output logic                             wb_write,
   output logic [$clog2(NUM_REGISTERS)-1:0] wb_reg,
   output logic [DATA_WIDTH-1:0]            wb_data,
   output logic [$clog2(FIFO_DEPTH):0]      fifo_count
`ifdef WB_PERF_COUNTERS_EN
   ,
   output logic [31:0]                      stall_cycles,
   output logic [31:0]                      mem_block_cycles
`endif
);

   localparam int IDX_W = $clog2(NUM_REGISTERS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   logic [IDX_W-1:0]      slot_rd   [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] slot_data [FIFO_DEPTH];

   logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [STV_W-1:0]      starve_q, starve_d;
   logic                  stall_q, stall_d;
   logic                  wb_write_q, wb_write_d;
   logic [IDX_W-1:0]      wb_reg_q, wb_reg_d;
   logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

   logic                  fifo_full, fifo_nonempty, push, pop, issue;
   logic [IDX_W-1:0]      issue_rd;
   logic [DATA_WIDTH-1:0] issue_data;

   // Occupancy is taken from the start of the cycle: a full FIFO refuses a
   // push even when it pops in the same cycle, and a fresh entry is not
   // visible to the arbiter until the next cycle.
   assign fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
   assign fifo_nonempty = (count_q != '0);
   assign mem_ready     = !fifo_full;
   assign push          = mem_valid && !fifo_full;

   // Buffer slots: each entry captures the offered result when the tail points at it.
   for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [IDX_W-1:0]      rd_q;
      logic [DATA_WIDTH-1:0] data_q;

      // Write this slot on an accepted push targeting it.
      always_ff @(posedge clk) begin
         if (push && (tail_q == PTR_W'(gi))) begin
            rd_q   <= mem_rd;
            data_q <= mem_data;
         end
      end

      assign slot_rd[gi]   = rd_q;
      assign slot_data[gi] = data_q;
   end

   // Arbitration: starved head first, then ALU, then any buffered result.
   always_comb begin
      pop        = 1'b0;
      issue      = 1'b0;
      issue_rd   = '0;
      issue_data = '0;
      if (stall_q && fifo_nonempty) begin
         pop        = 1'b1;
         issue      = 1'b1;
         issue_rd   = slot_rd[head_q];
         issue_data = slot_data[head_q];
      end else if (alu_valid) begin
         issue      = 1'b1;
         issue_rd   = alu_rd;
         issue_data = alu_data;
      end else if (fifo_nonempty) begin
         pop        = 1'b1;
         issue      = 1'b1;
         issue_rd   = slot_rd[head_q];
         issue_data = slot_data[head_q];
      end
   end

   // Next-state: writeback port, FIFO pointers/count, starvation and stall.
   always_comb begin
      // x0 is never written; an issue to it just consumes the source.
      wb_write_d = issue && (issue_rd != '0);
      wb_reg_d   = wb_reg_q;
      wb_data_d  = wb_data_q;
      if (wb_write_d) begin
         wb_reg_d  = issue_rd;
         wb_data_d = issue_data;
      end

      head_d  = pop  ? head_q + PTR_W'(1) : head_q;
      tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end

      starve_d = '0;
      if (fifo_nonempty && !pop) begin
         starve_d = (starve_q == STV_W'(STARVE_LIMIT)) ? starve_q : starve_q + STV_W'(1);
      end

      // Raise the stall as the counter hits the limit; hold it until the head drains.
      stall_d = !pop && (stall_q || (starve_d == STV_W'(STARVE_LIMIT)));
   end

   // Control and writeback registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         starve_q   <= '0;
         stall_q    <= 1'b0;
         wb_write_q <= 1'b0;
         wb_reg_q   <= '0;
         wb_data_q  <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         starve_q   <= starve_d;
         stall_q    <= stall_d;
         wb_write_q <= wb_write_d;
         wb_reg_q   <= wb_reg_d;
         wb_data_q  <= wb_data_d;
      end
   end

   assign alu_stall  = stall_q;
   assign wb_write   = wb_write_q;
   assign wb_reg     = wb_reg_q;
   assign wb_data    = wb_data_q;
   assign fifo_count = count_q;

`ifdef WB_PERF_COUNTERS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] mem_block_cycles_q, mem_block_cycles_d;

   // Free-running event counters; they wrap naturally at 2^32.
   always_comb begin
      stall_cycles_d     = stall_cycles_q + (stall_q ? 32'd1 : 32'd0);
      mem_block_cycles_d = mem_block_cycles_q + ((mem_valid && fifo_full) ? 32'd1 : 32'd0);
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q     <= '0;
         mem_block_cycles_q <= '0;
      end else begin
         stall_cycles_q     <= stall_cycles_d;
         mem_block_cycles_q <= mem_block_cycles_d;
      end
   end

   assign stall_cycles     = stall_cycles_q;
   assign mem_block_cycles = mem_block_cycles_q;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios with constant expectations,
// then randomized traffic checked against a queue-based reference model.
module tb_regfile_writeback;
   localparam int DW = 32;
   localparam int NR = 32;
   localparam int IW = 5;
   localparam int FD = 2;
   localparam int SL = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          alu_valid = 1'b0;
   logic [IW-1:0] alu_rd = '0;
   logic [DW-1:0] alu_data = '0;
   logic          alu_stall;
   logic          mem_valid = 1'b0;
   logic          mem_ready;
   logic [IW-1:0] mem_rd = '0;
   logic [DW-1:0] mem_data = '0;
   logic          wb_write;
   logic [IW-1:0] wb_reg;
   logic [DW-1:0] wb_data;
   logic [CW-1:0] fifo_count;
`ifdef WB_PERF_COUNTERS_EN
   logic [31:0]   stall_cycles;
   logic [31:0]   mem_block_cycles;
`endif

   always #5 clk = ~clk;

   regfile_writeback #(
      .DATA_WIDTH(DW), .NUM_REGISTERS(NR), .FIFO_DEPTH(FD), .STARVE_LIMIT(SL)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data), .fifo_count(fifo_count)
`ifdef WB_PERF_COUNTERS_EN
      , .stall_cycles(stall_cycles), .mem_block_cycles(mem_block_cycles)
`endif
   );

   // Reference model state
   typedef struct {
      logic [IW-1:0] rd;
      logic [DW-1:0] data;
   } ent_t;
   ent_t          mq[$];
   int            lost;
   bit            m_stall;
   bit            m_wbw;
   logic [IW-1:0] m_wbr;
   logic [DW-1:0] m_wbd;
   int unsigned   m_stall_cyc;
   int unsigned   m_block_cyc;

   int n_cmp = 0;
   int n_err = 0;

   task automatic model_clear();
      mq.delete();
      lost        = 0;
      m_stall     = 0;
      m_wbw       = 0;
      m_wbr       = '0;
      m_wbd       = '0;
      m_stall_cyc = 0;
      m_block_cyc = 0;
   endtask

   // Advance the model by the rules for the current inputs, then clock the DUT.
   task automatic step();
      ent_t          e;
      bit            ne, pop, iss, push;
      logic [IW-1:0] ird;
      logic [DW-1:0] idat;
      ne   = (mq.size() != 0);
      push = mem_valid && (mq.size() < FD);
      if (m_stall) m_stall_cyc++;
      if (mem_valid && !(mq.size() < FD)) m_block_cyc++;
      pop = 0; iss = 0; ird = '0; idat = '0;
      if (m_stall && ne) pop = 1;
      else if (alu_valid) begin iss = 1; ird = alu_rd; idat = alu_data; end
      else if (ne) pop = 1;
      if (pop) begin
         e = mq.pop_front();
         iss = 1; ird = e.rd; idat = e.data;
      end
      m_wbw = iss && (ird != 0);
      if (m_wbw) begin m_wbr = ird; m_wbd = idat; end
      if (ne && !pop) lost++; else lost = 0;
      m_stall = !pop && (m_stall || lost >= SL);
      if (push) begin
         e.rd = mem_rd; e.data = mem_data;
         mq.push_back(e);
      end
      @(posedge clk); #1;
      $display("[%0t] alu_v=%0b rd=%0d mem_v=%0b rd=%0d -> wb_write=%0b wb_reg=%0d wb_data=%h stall=%0b cnt=%0d",
               $time, alu_valid, alu_rd, mem_valid, mem_rd, wb_write, wb_reg, wb_data, alu_stall, fifo_count);
   endtask

   task automatic apply_reset();
      alu_valid = 0; mem_valid = 0;
      rst_n = 0;
      model_clear();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      #1 rst_n = 0;
      #1;
      n_cmp++;
      if ({wb_write, wb_reg, wb_data, alu_stall, fifo_count} !== '0) begin
         n_err++;
         $display("FAIL reset_state: got w=%0b r=%0d d=%h stall=%0b cnt=%0d, want all zero",
                  wb_write, wb_reg, wb_data, alu_stall, fifo_count);
      end
      model_clear();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      #1;
      n_cmp++;
      if (mem_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: got mem_ready=%0b want 1", mem_ready);
      end
   endtask

   task automatic test_alu();
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      step();
      n_cmp++;
      if ({wb_write, wb_reg, wb_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
         n_err++;
         $display("FAIL alu_issue: got w=%0b r=%0d d=%h want w=1 r=5 d=deadbeef", wb_write, wb_reg, wb_data);
      end
      alu_rd = 0; alu_data = 32'h00001111;
      step();
      n_cmp++;
      if ({wb_write, wb_reg, wb_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
         n_err++;
         $display("FAIL alu_x0: got w=%0b r=%0d d=%h want w=0 r=5 d=deadbeef", wb_write, wb_reg, wb_data);
      end
      alu_valid = 0;
      step();
      n_cmp++;
      if (wb_write !== 1'b0) begin
         n_err++;
         $display("FAIL alu_idle: got w=%0b want 0", wb_write);
      end
   endtask

   task automatic test_mem();
      mem_valid = 1; mem_rd = 7; mem_data = 32'h12345678;
      step();
      mem_valid = 0;
      n_cmp++;
      if ({wb_write, fifo_count} !== {1'b0, 2'd1}) begin
         n_err++;
         $display("FAIL mem_buffered: got w=%0b cnt=%0d want w=0 cnt=1", wb_write, fifo_count);
      end
      step();
      n_cmp++;
      if ({wb_write, wb_reg, wb_data, fifo_count} !== {1'b1, 5'd7, 32'h12345678, 2'd0}) begin
         n_err++;
         $display("FAIL mem_issue: got w=%0b r=%0d d=%h cnt=%0d want w=1 r=7 d=12345678 cnt=0",
                  wb_write, wb_reg, wb_data, fifo_count);
      end
   endtask

   task automatic test_full();
      logic [IW-1:0] exp_reg [6];
      logic          exp_rdy [6];
      logic [CW-1:0] exp_cnt [6];
      exp_reg = '{5'd1, 5'd2, 5'd3, 5'd10, 5'd11, 5'd12};
      exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_cnt = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
      apply_reset();
      for (int c = 0; c < 6; c++) begin
         alu_valid = (c < 3);
         alu_rd    = IW'(c + 1);
         alu_data  = 32'hA1000000 + c;
         // third result stays offered until accepted
         mem_valid = (c < 5);
         mem_rd    = (c < 2) ? IW'(10 + c) : 5'd12;
         mem_data  = 32'hB0000000 + ((c < 2) ? c : 2);
         n_cmp++;
         if (exp_rdy[c] !== 1'bx && c < 5 && mem_ready !== exp_rdy[c]) begin
            n_err++;
            $display("FAIL full_ready[%0d]: got mem_ready=%0b want %0b", c, mem_ready, exp_rdy[c]);
         end
         step();
         n_cmp++;
         if ({wb_write, wb_reg, fifo_count} !== {1'b1, exp_reg[c], exp_cnt[c]}) begin
            n_err++;
            $display("FAIL full_order[%0d]: got w=%0b r=%0d cnt=%0d want w=1 r=%0d cnt=%0d",
                     c, wb_write, wb_reg, fifo_count, exp_reg[c], exp_cnt[c]);
         end
      end
      mem_valid = 0;
`ifdef WB_PERF_COUNTERS_EN
      n_cmp++;
      if (mem_block_cycles !== 32'd2) begin
         n_err++;
         $display("FAIL perf_block: got mem_block_cycles=%0d want 2", mem_block_cycles);
      end
`endif
   endtask

   task automatic test_starve();
      apply_reset();
      alu_valid = 1; alu_rd = 21; alu_data = 32'hCAFE0021;
      mem_valid = 1; mem_rd = 9; mem_data = 32'h99999999;
      step();
      mem_valid = 0;
      for (int c = 1; c <= 4; c++) begin
         step();
         n_cmp++;
         if ({alu_stall, wb_reg} !== {(c == 4) ? 1'b1 : 1'b0, 5'd21}) begin
            n_err++;
            $display("FAIL starve_lost[%0d]: got stall=%0b r=%0d want stall=%0b r=21",
                     c, alu_stall, wb_reg, (c == 4));
         end
      end
      // ALU result held upstream while stalled
      step();
      n_cmp++;
      if ({wb_write, wb_reg, wb_data, alu_stall, fifo_count} !== {1'b1, 5'd9, 32'h99999999, 1'b0, 2'd0}) begin
         n_err++;
         $display("FAIL starve_drain: got w=%0b r=%0d d=%h stall=%0b cnt=%0d want w=1 r=9 d=99999999 stall=0 cnt=0",
                  wb_write, wb_reg, wb_data, alu_stall, fifo_count);
      end
      step();
      n_cmp++;
      if ({wb_write, wb_reg, wb_data} !== {1'b1, 5'd21, 32'hCAFE0021}) begin
         n_err++;
         $display("FAIL starve_alu_resume: got w=%0b r=%0d d=%h want w=1 r=21 d=cafe0021", wb_write, wb_reg, wb_data);
      end
      alu_valid = 0;
`ifdef WB_PERF_COUNTERS_EN
      n_cmp++;
      if (stall_cycles !== 32'd1) begin
         n_err++;
         $display("FAIL perf_stall: got stall_cycles=%0d want 1", stall_cycles);
      end
`endif
   endtask

   task automatic test_reset_mid();
      apply_reset();
      alu_valid = 1; alu_rd = 21; alu_data = 32'h0000BEEF;
      for (int c = 0; c < 5; c++) begin
         mem_valid = (c < 2);
         mem_rd    = IW'(3 + c);
         mem_data  = 32'hD0000000 + c;
         step();
      end
      n_cmp++;
      if ({alu_stall, fifo_count, wb_write} !== {1'b1, 2'd2, 1'b1}) begin
         n_err++;
         $display("FAIL midrst_setup: got stall=%0b cnt=%0d w=%0b want stall=1 cnt=2 w=1",
                  alu_stall, fifo_count, wb_write);
      end
      #3 rst_n = 0;
      #1;
      n_cmp++;
      if ({wb_write, alu_stall, fifo_count} !== '0) begin
         n_err++;
         $display("FAIL midrst_async: got w=%0b stall=%0b cnt=%0d want all zero", wb_write, alu_stall, fifo_count);
      end
      model_clear();
      alu_valid = 0; mem_valid = 0;
      @(negedge clk);
      rst_n = 1;
      for (int c = 0; c < 3; c++) begin
         step();
         n_cmp++;
         if ({wb_write, fifo_count} !== {1'b0, 2'd0}) begin
            n_err++;
            $display("FAIL midrst_stale[%0d]: got w=%0b cnt=%0d want w=0 cnt=0", c, wb_write, fifo_count);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         if (!alu_stall) begin
            alu_valid = ($urandom_range(0, 9) < 6);
            alu_rd    = IW'($urandom_range(0, NR - 1));
            alu_data  = $urandom;
         end
         if (!(mem_valid && !mem_ready)) begin
            mem_valid = ($urandom_range(0, 1) == 1);
            mem_rd    = IW'($urandom_range(0, NR - 1));
            mem_data  = $urandom;
         end
         n_cmp++;
         if (mem_ready !== (mq.size() < FD)) begin
            n_err++;
            $display("FAIL rand_ready[%0d]: got %0b want %0b", c, mem_ready, (mq.size() < FD));
         end
         step();
         n_cmp++;
         if ({wb_write, wb_reg, wb_data, alu_stall, fifo_count} !== {m_wbw, m_wbr, m_wbd, m_stall, CW'(mq.size())}) begin
            n_err++;
            $display("FAIL rand_out[%0d]: got w=%0b r=%0d d=%h stall=%0b cnt=%0d want w=%0b r=%0d d=%h stall=%0b cnt=%0d",
                     c, wb_write, wb_reg, wb_data, alu_stall, fifo_count,
                     m_wbw, m_wbr, m_wbd, m_stall, mq.size());
         end
      end
      alu_valid = 0; mem_valid = 0;
`ifdef WB_PERF_COUNTERS_EN
      n_cmp++;
      if ({stall_cycles, mem_block_cycles} !== {m_stall_cyc, m_block_cyc}) begin
         n_err++;
         $display("FAIL rand_perf: got stall=%0d block=%0d want stall=%0d block=%0d",
                  stall_cycles, mem_block_cycles, m_stall_cyc, m_block_cyc);
      end
`endif
   endtask

   initial begin
      model_clear();
      test_reset();
      test_alu();
      test_mem();
      test_full();
      test_starve();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
